// File: rtl/truth_table_driver.sv
// truth_table_driver: steps A/B/C through the 8 input combinations of the
// three-input logic lab block, one per debounced button press, and captures
// the block's O1/O2 responses into 8-entry tables for LED display.
// Optional macro TRUTH_TABLE_AUTO_RUN_EN adds an auto_en input and a timer
// that steps automatically every AUTO_PERIOD cycles.
module truth_table_driver #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_step,
  input  logic       btn_clear,
`ifdef TRUTH_TABLE_AUTO_RUN_EN
  input  logic       auto_en,
`endif
  input  logic       o1_in,
  input  logic       o2_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic [2:0] index,
  output logic [7:0] o1_table,
  output logic [7:0] o2_table,
  output logic [7:0] valid,
  output logic       done
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic            step_s1_q, step_s2_q;
  logic            clr_s1_q, clr_s2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            deb_q, deb_d;
  logic            deb_prev_q, deb_prev_d;
  logic            step_pulse_q, step_pulse_d;
  logic            step;

  logic [2:0]      state_q, state_d;
  logic [2:0]      index_q, index_d;
  logic [7:0]      o1_table_q, o1_table_d;
  logic [7:0]      o2_table_q, o2_table_d;
  logic [7:0]      valid_q, valid_d;
  logic            done_q, done_d;

  // Two-flop synchronizers for the raw buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      clr_s1_q  <= 1'b0;
      clr_s2_q  <= 1'b0;
    end else begin
      step_s1_q <= btn_step;
      step_s2_q <= step_s1_q;
      clr_s1_q  <= btn_clear;
      clr_s2_q  <= clr_s1_q;
    end
  end

  // Debounce: the level only follows the synced button after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles; the pulse marks a 0->1 flip only
  always_comb begin
    db_cnt_d     = '0;
    deb_d        = deb_q;
    deb_prev_d   = deb_q;
    step_pulse_d = deb_q & ~deb_prev_q;
    if (step_s2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = step_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q     <= '0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      step_pulse_q <= step_pulse_d;
    end
  end

`ifdef TRUTH_TABLE_AUTO_RUN_EN
  localparam int AP_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);

  logic            auto_s1_q, auto_s2_q;
  logic [AP_W-1:0] auto_cnt_q, auto_cnt_d;
  logic            auto_pulse_q, auto_pulse_d;

  // Free-running auto-step timer, held at zero while disabled or clearing
  always_comb begin
    auto_cnt_d   = '0;
    auto_pulse_d = 1'b0;
    if (auto_s2_q && !clr_s2_q) begin
      if (auto_cnt_q == AP_LAST) begin
        auto_pulse_d = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 1'b1;
      end
    end
  end

  // Auto-run synchronizer and timer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_s1_q    <= 1'b0;
      auto_s2_q    <= 1'b0;
      auto_cnt_q   <= '0;
      auto_pulse_q <= 1'b0;
    end else begin
      auto_s1_q    <= auto_en;
      auto_s2_q    <= auto_s1_q;
      auto_cnt_q   <= auto_cnt_d;
      auto_pulse_q <= auto_pulse_d;
    end
  end

  assign step = step_pulse_q | auto_pulse_q;
`else
  assign step = step_pulse_q;
`endif

  // Sweep FSM: clear overrides everything; steps outside IDLE/DONE are dropped
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    o1_table_d = o1_table_q;
    o2_table_d = o2_table_q;
    valid_d    = valid_q;
    done_d     = done_q;
    if (clr_s2_q) begin
      state_d    = ST_IDLE;
      index_d    = 3'd0;
      o1_table_d = 8'h00;
      o2_table_d = 8'h00;
      valid_d    = 8'h00;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (step) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          o1_table_d[index_q] = o1_in;
          o2_table_d[index_q] = o2_in;
          valid_d[index_q]    = 1'b1;
          state_d             = ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (index_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            index_d = index_q + 3'd1;
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (step) begin
            index_d    = 3'd0;
            o1_table_d = 8'h00;
            o2_table_d = 8'h00;
            valid_d    = 8'h00;
            done_d     = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sweep state and result table registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= 3'd0;
      o1_table_q <= 8'h00;
      o2_table_q <= 8'h00;
      valid_q    <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      o1_table_q <= o1_table_d;
      o2_table_q <= o2_table_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign {a_out, b_out, c_out} = index_q;
  assign index    = index_q;
  assign o1_table = o1_table_q;
  assign o2_table = o2_table_q;
  assign valid    = valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_truth_table_driver.sv
// Testbench for truth_table_driver with DEBOUNCE_CYCLES=4 (and AUTO_PERIOD=16
// when TRUTH_TABLE_AUTO_RUN_EN is defined).
module tb_truth_table_driver;

  localparam int DB = 4;
  localparam int AP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_step;
  logic       btn_clear;
  logic       o1_in;
  logic       o2_in;
  logic       a_out, b_out, c_out;
  logic [2:0] index;
  logic [7:0] o1_table, o2_table, valid;
  logic       done;
`ifdef TRUTH_TABLE_AUTO_RUN_EN
  logic       auto_en;
`endif

  logic       use_model;
  logic       f1, f2;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] vld;
    logic [7:0] o1;
    logic [7:0] o2;
    logic       dn;
  } vec_t;

  vec_t vecs [9];

  truth_table_driver #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD    (AP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_step (btn_step),
    .btn_clear(btn_clear),
`ifdef TRUTH_TABLE_AUTO_RUN_EN
    .auto_en  (auto_en),
`endif
    .o1_in    (o1_in),
    .o2_in    (o2_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .c_out    (c_out),
    .index    (index),
    .o1_table (o1_table),
    .o2_table (o2_table),
    .valid    (valid),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Combinational lab block: O1 = AC + A'B, O2 = (A + C')BC, or fixed levels
  always_comb begin
    o1_in = f1;
    o2_in = f2;
    if (use_model) begin
      o1_in = (a_out & c_out) | (~a_out & b_out);
      o2_in = (a_out | ~c_out) & b_out & c_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic press();
    btn_step = 1'b1;
    repeat (20) @(negedge clk);
    btn_step = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, cyc;
    bit got1, got2, got_done;

    vecs[0] = '{3'd1, 8'h01, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{3'd2, 8'h03, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{3'd3, 8'h07, 8'h04, 8'h00, 1'b0};
    vecs[3] = '{3'd4, 8'h0F, 8'h0C, 8'h00, 1'b0};
    vecs[4] = '{3'd5, 8'h1F, 8'h0C, 8'h00, 1'b0};
    vecs[5] = '{3'd6, 8'h3F, 8'h2C, 8'h00, 1'b0};
    vecs[6] = '{3'd7, 8'h7F, 8'h2C, 8'h00, 1'b0};
    vecs[7] = '{3'd7, 8'hFF, 8'hAC, 8'h80, 1'b1};
    vecs[8] = '{3'd0, 8'h00, 8'h00, 8'h00, 1'b0};

    btn_step  = 1'b0;
    btn_clear = 1'b0;
    use_model = 1'b0;
    f1        = 1'b0;
    f2        = 1'b0;
`ifdef TRUTH_TABLE_AUTO_RUN_EN
    auto_en   = 1'b0;
`endif
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {index, a_out, b_out, c_out, valid, o1_table, o2_table, done}, 32'h0);
    reset = 1'b0;

    // Idle after reset: nothing moves for 50 cycles
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_hold", {index, a_out, b_out, c_out, valid, done}, 32'h0);
    end

    // Single clean press with O1=1, O2=0; track capture/advance timing
    f1 = 1'b1;
    f2 = 1'b0;
    btn_step = 1'b1;
    repeat (9) @(negedge clk);
    check("press_no_capture_yet", {24'h0, valid}, 32'h00);
    @(negedge clk);
    check("press_capture_edge10", {21'h0, index, valid}, {21'h0, 3'd0, 8'h01});
    @(negedge clk);
    check("press_advance_edge11", {29'h0, index}, 32'd1);
    repeat (9) @(negedge clk);
    btn_step = 1'b0;
    repeat (20) @(negedge clk);
    check("press_index", {29'h0, index}, 32'd1);
    check("press_abc", {29'h0, a_out, b_out, c_out}, 32'd1);
    check("press_o1", {24'h0, o1_table}, 32'h01);
    check("press_o2", {24'h0, o2_table}, 32'h00);
    check("press_valid", {24'h0, valid}, 32'h01);

    // Bouncing button followed by a stable press: exactly one step
    for (int i = 0; i < 30; i++) begin
      btn_step = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    check("bounce_no_step", {29'h0, index}, 32'd1);
    press();
    check("bounce_index", {29'h0, index}, 32'd2);
    check("bounce_valid", {24'h0, valid}, 32'h03);

    // Clear pulse returns to the start of the sweep
    pulse_clear();
    check("clear_state", {index, valid, o1_table, o2_table, done}, 32'h0);

    // Full sweep against the lab functions, plus the wrapping ninth press
    use_model = 1'b1;
    for (int k = 0; k < 9; k++) begin
      press();
      check($sformatf("sweep%0d_index", k + 1), {29'h0, index}, {29'h0, vecs[k].idx});
      check($sformatf("sweep%0d_abc", k + 1), {29'h0, a_out, b_out, c_out}, {29'h0, vecs[k].idx});
      check($sformatf("sweep%0d_valid", k + 1), {24'h0, valid}, {24'h0, vecs[k].vld});
      check($sformatf("sweep%0d_o1", k + 1), {24'h0, o1_table}, {24'h0, vecs[k].o1});
      check($sformatf("sweep%0d_o2", k + 1), {24'h0, o2_table}, {24'h0, vecs[k].o2});
      check($sformatf("sweep%0d_done", k + 1), {31'h0, done}, {31'h0, vecs[k].dn});
    end

    // Clear coinciding with a step pulse after three captures: clear wins
    repeat (3) press();
    check("pre_clear_valid", {24'h0, valid}, 32'h07);
    btn_step = 1'b1;
    repeat (5) @(negedge clk);
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
    repeat (14) @(negedge clk);
    btn_step = 1'b0;
    repeat (20) @(negedge clk);
    check("clear_wins_index", {29'h0, index}, 32'd0);
    check("clear_wins_valid", {24'h0, valid}, 32'h00);
    check("clear_wins_tables", {16'h0, o1_table, o2_table}, 32'h0);

    // Clear held high blocks stepping
    btn_clear = 1'b1;
    press();
    check("clear_held", {index, valid, done}, 32'h0);
    btn_clear = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-sweep aborts immediately and keeps no partial capture
    press();
    check("pre_reset_index", {29'h0, index}, 32'd1);
    btn_step = 1'b1;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset", {index, valid, o1_table, o2_table, done}, 32'h0);
    btn_step = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset", {index, valid, o1_table, o2_table, done}, 32'h0);

`ifdef TRUTH_TABLE_AUTO_RUN_EN
    // Auto-run: one step per AUTO_PERIOD cycles, done after eight periods
    t1 = 0; t2 = 0; got1 = 0; got2 = 0; got_done = 0; cyc = 0;
    auto_en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (!got1 && index == 3'd1) begin got1 = 1; t1 = i; end
      if (!got2 && index == 3'd2) begin got2 = 1; t2 = i; end
      if (done) begin got_done = 1; cyc = i; break; end
    end
    auto_en = 1'b0;
    check("auto_done_seen", {31'h0, got_done}, 32'd1);
    check("auto_period", t2 - t1, AP);
    check("auto_done_window", {31'h0, (cyc >= 8 * AP) && (cyc <= 9 * AP)}, 32'd1);
    check("auto_final", {index, valid}, {3'd7, 8'hFF});
    repeat (5) @(negedge clk);
    pulse_clear();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/truth_table_driver.md
Name: truth_table_driver

Overview:
- Upstream stimulus and capture stage for the three-input combinational logic-function lab block.
- Drives A/B/C through all 8 input combinations, one per debounced button press.
- Samples the two function outputs for each combination into 8-entry result tables for LED display.
- Sits between the board buttons and the combinational block; the tables feed the LED outputs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced button changes (5 ms at 100 MHz); minimum 2
AUTO_PERIOD, 100000000, cycles between automatic steps when the optional feature is active; minimum 8

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_step  input  1  raw, unsynchronized step button
btn_clear  input  1  raw, unsynchronized clear button (synchronized, not debounced)
o1_in  input  1  O1 from the combinational block
o2_in  input  1  O2 from the combinational block
a_out  output  1  A to the combinational block (index bit 2)
b_out  output  1  B (index bit 1)
c_out  output  1  C (index bit 0)
index  output  3  current combination number
o1_table  output  8  captured O1; bit i holds the result for combination i
o2_table  output  8  captured O2; bit i holds the result for combination i
valid  output  8  bit i set once combination i has been captured
done  output  1  high when all 8 combinations are captured

Behaviour:
- Reset (asynchronous, active-high) values:
  - index=0, a/b/c=0, o1_table=0, o2_table=0, valid=0, done=0.
  - state=IDLE; synchronizers, debounce counter and debounced level all 0.
- Input synchronization:
  - btn_step and btn_clear each pass through a 2-FF synchronizer.
- Debounce (btn_step only):
  - Counter increments while the synced level differs from the debounced level.
  - Counter resets to 0 on any cycle where they are equal.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES-1 while still differing.
- Step pulse:
  - One-cycle registered pulse on a debounced 0->1 transition only.
  - Release never steps.
  - Raw rise to step pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- a_out/b_out/c_out are always the registered index bits {a,b,c}=index.
- State machine:
  - IDLE: step -> SETTLE.
  - SETTLE: one cycle so the combinational outputs settle; -> CAPTURE.
  - CAPTURE: o1_table[index]<=o1_in, o2_table[index]<=o2_in, valid[index]<=1; -> ADVANCE.
  - ADVANCE: if index==7 then done<=1 -> DONE; else index<=index+1 -> IDLE.
  - DONE: index stays 7; step -> index<=0, tables=0, valid=0, done=0 -> IDLE (wrap restarts the sweep).
- Step pulses arriving in SETTLE, CAPTURE or ADVANCE are dropped, not queued.
- Synced btn_clear high:
  - Next edge: index=0, tables=0, valid=0, done=0, state=IDLE.
  - Clear has priority over a simultaneous step or capture in any state.
  - Clear held high keeps the block in this state.
- Reset mid-sweep aborts immediately to reset values; no partial capture is retained.

Optional Feature:
- Macro: TRUTH_TABLE_AUTO_RUN_EN.
- Defined:
  - Adds input port auto_en (1 bit, synchronized by 2-FF).
  - While synced auto_en=1, a free-running counter issues an internal step pulse every AUTO_PERIOD cycles.
  - The internal pulse is OR'd with the button step pulse; the same drop rules apply.
  - The counter resets to 0 whenever auto_en=0 or clear is active.
- Undefined: no auto_en port, no timer logic; stepping is by button only.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4.)
1. Reset released, no buttons -> index=0, a/b/c=000, valid=00000000, done=0 held 50 cycles.
2. btn_step high 20 cycles, o1_in=1, o2_in=0 -> exactly one step; index=1, o1_table=00000001, o2_table=0, valid=00000001; the first step pulse occurs 7 cycles after the raw rise.
3. btn_step bouncing 1/0 every 2 cycles for 30 cycles, then stable high -> exactly one step, index advances by 1 only.
4. Eight clean presses with o1_in/o2_in modeling O1=AC+A'B and O2=(A+C')BC -> o1_table=10101100, o2_table=10000000, valid=FF, done=1, index=7; a ninth press -> index=0, tables=0, valid=0, done=0.
5. After 3 captures, btn_clear pulsed in the same cycle as a step pulse -> clear wins: index=0, valid=0, no capture.
6. With TRUTH_TABLE_AUTO_RUN_EN, AUTO_PERIOD=16, auto_en=1, no button -> index increments every 16 cycles; done=1 after 8 periods.
